// File: rtl/ase_cci_tx_arbiter.sv
// ase_cci_tx_arbiter
//   N-channel CCI TX request buffer and round-robin arbiter. Each AFU TX channel
//   pushes into its own FIFO; the FIFOs are drained one request per cycle into a
//   single registered valid/ready output slot toward the emulator.
//
// Ports
//   clk_32ui, sys_reset          clock, synchronous active-high reset
//   afu_tx_hdr/data/valid        per-channel push (channel i at slice i)
//   afu_tx_almostfull            per-channel back-pressure, decoded from FIFO count
//   emu_tx_hdr/data/ch/valid     output slot contents and source channel
//   emu_tx_ready                 emulator takes the slot this cycle
//   fill_level                   per-channel FIFO count
//   ovf_err                      sticky per-channel overflow (push while full)
module ase_cci_tx_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned HDR_W       = 61,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_SLACK = 2
) (
    input  logic                                 clk_32ui,
    input  logic                                 sys_reset,
    input  logic [NUM_CH*HDR_W-1:0]              afu_tx_hdr,
    input  logic [NUM_CH*DATA_W-1:0]             afu_tx_data,
    input  logic [NUM_CH-1:0]                    afu_tx_valid,
    output logic [NUM_CH-1:0]                    afu_tx_almostfull,
    output logic [HDR_W-1:0]                     emu_tx_hdr,
    output logic [DATA_W-1:0]                    emu_tx_data,
    output logic [$clog2(NUM_CH):0]              emu_tx_ch,
    output logic                                 emu_tx_valid,
    input  logic                                 emu_tx_ready,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  fill_level,
    output logic [NUM_CH-1:0]                    ovf_err
);

    localparam int unsigned CH_W  = $clog2(NUM_CH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = HDR_W + DATA_W;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_SLACK);

    // FIFO storage and per-channel state
    logic [ENT_W-1:0] mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    // Output slot
    logic              valid_q, valid_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              slot_free;
    logic              pick_vld;
    logic [CH_W-1:0]   pick;
    logic [ENT_W-1:0]  head;
    int unsigned       rr_idx;

    // Round-robin pick. Offsets are scanned from farthest to nearest so the
    // closest non-empty channel after last_grant is the one that sticks.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        rr_idx   = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            nonempty[i] = (count_q[i] != '0);
        end
        for (int off = int'(NUM_CH); off > 0; off--) begin
            rr_idx = (32'(last_grant_q) + 32'(off)) % NUM_CH;
            if (nonempty[rr_idx]) begin
                pick_vld = 1'b1;
                pick     = CH_W'(rr_idx);
            end
        end
    end

    always_comb begin
        slot_free = !valid_q || emu_tx_ready;
        head      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pop[i] = slot_free && pick_vld && (pick == CH_W'(i));
            if (pop[i]) begin
                head = mem_q[i][rd_ptr_q[i]];
            end
        end

        // A push into a full FIFO is still accepted when that channel pops in
        // the same cycle: the write lands in the slot being freed.
        for (int i = 0; i < int'(NUM_CH); i++) begin
            push[i]     = afu_tx_valid[i] && ((count_q[i] != FULL_CNT) || pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i];
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (pop[i] && !push[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
            ovf_d[i] = ovf_q[i] || (afu_tx_valid[i] && !push[i]);
        end

        valid_d      = valid_q;
        hdr_d        = hdr_q;
        data_d       = data_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        if (slot_free) begin
            valid_d = pick_vld;
            if (pick_vld) begin
                hdr_d        = head[ENT_W-1:DATA_W];
                data_d       = head[DATA_W-1:0];
                ch_d         = pick;
                last_grant_d = pick;
            end
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk_32ui) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {afu_tx_hdr[i*HDR_W +: HDR_W],
                                          afu_tx_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk_32ui) begin
        if (sys_reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            ovf_q        <= '0;
            valid_q      <= 1'b0;
            hdr_q        <= '0;
            data_q       <= '0;
            ch_q         <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            hdr_q        <= hdr_d;
            data_q       <= data_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            afu_tx_almostfull[i]            = (count_q[i] >= AFULL_CNT);
            fill_level[i*CNT_W +: CNT_W]    = count_q[i];
        end
    end

    assign emu_tx_valid = valid_q;
    assign emu_tx_hdr   = hdr_q;
    assign emu_tx_data  = data_q;
    assign emu_tx_ch    = ch_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_ase_cci_tx_arbiter.sv
// Self-checking bench for ase_cci_tx_arbiter. A queue-per-channel reference
// model is advanced once per clock edge from the inputs applied to that edge.
module tb_ase_cci_tx_arbiter;

    localparam int NUM_CH = 2;
    localparam int HDR_W  = 61;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 8;
    localparam int SLACK  = 2;
    localparam int CH_W   = $clog2(NUM_CH) + 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int ENT_W  = HDR_W + DATA_W;

    typedef logic [ENT_W-1:0] ent_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_CH*HDR_W-1:0]     tx_hdr;
    logic [NUM_CH*DATA_W-1:0]    tx_data;
    logic [NUM_CH-1:0]           tx_valid;
    logic [NUM_CH-1:0]           afull;
    logic [HDR_W-1:0]            e_hdr;
    logic [DATA_W-1:0]           e_data;
    logic [CH_W-1:0]             e_ch;
    logic                        e_valid;
    logic                        e_ready;
    logic [NUM_CH*CNT_W-1:0]     fill;
    logic [NUM_CH-1:0]           ovf;

    always #5 clk = ~clk;

    ase_cci_tx_arbiter #(
        .NUM_CH     (NUM_CH),
        .HDR_W      (HDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .AFULL_SLACK(SLACK)
    ) dut (
        .clk_32ui         (clk),
        .sys_reset        (rst),
        .afu_tx_hdr       (tx_hdr),
        .afu_tx_data      (tx_data),
        .afu_tx_valid     (tx_valid),
        .afu_tx_almostfull(afull),
        .emu_tx_hdr       (e_hdr),
        .emu_tx_data      (e_data),
        .emu_tx_ch        (e_ch),
        .emu_tx_valid     (e_valid),
        .emu_tx_ready     (e_ready),
        .fill_level       (fill),
        .ovf_err          (ovf)
    );

    // Reference model
    ent_t              mq[NUM_CH][$];
    bit                m_valid;
    ent_t              m_slot;
    int                m_ch;
    int                m_last;
    bit [NUM_CH-1:0]   m_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic randomize_payload();
        for (int j = 0; j < NUM_CH * DATA_W / 32; j++) tx_data[j*32 +: 32] = $urandom;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_hdr[c*HDR_W +: HDR_W] = {29'($urandom), $urandom};
        end
    endtask

    // Advance model by one edge, then let the DUT take the same edge.
    task automatic tick();
        int              sz[NUM_CH];
        bit [NUM_CH-1:0] popped;
        int              w;
        int              c;
        popped = '0;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            m_valid = 0;
            m_slot  = '0;
            m_ch    = 0;
            m_last  = NUM_CH - 1;
            m_ovf   = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
            if (!m_valid || e_ready) begin
                w = -1;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_last + k) % NUM_CH;
                    if (w < 0 && sz[c] > 0) w = c;
                end
                if (w >= 0) begin
                    m_slot    = mq[w].pop_front();
                    m_ch      = w;
                    m_last    = w;
                    m_valid   = 1;
                    popped[w] = 1'b1;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (tx_valid[i]) begin
                    if (sz[i] < DEPTH || popped[i])
                        mq[i].push_back({tx_hdr[i*HDR_W +: HDR_W], tx_data[i*DATA_W +: DATA_W]});
                    else
                        m_ovf[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_valid = '0;
        e_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (e_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", e_valid);
        else n_pass++;
        n_checks++;
        if (e_hdr !== '0 || e_data !== '0 || e_ch !== '0)
            $display("FAIL reset_slot: hdr=%h ch=%0d want 0", e_hdr, e_ch);
        else n_pass++;
        n_checks++;
        if (fill !== '0 || afull !== '0 || ovf !== '0)
            $display("FAIL reset_status: fill=%h afull=%b ovf=%b want 0", fill, afull, ovf);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        randomize_payload();
        tx_hdr[0 +: HDR_W] = 61'h1A5;
        tx_valid = 2'b01;
        e_ready  = 1'b1;
        tick();
        tx_valid = '0;
        n_checks++;
        if (e_valid !== 1'b0) $display("FAIL latency_early: valid=%b want 0", e_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (e_valid !== 1'b1 || e_hdr !== 61'h1A5 || e_ch !== '0)
            $display("FAIL latency_out: valid=%b hdr=%h ch=%0d want 1 1a5 0", e_valid, e_hdr, e_ch);
        else n_pass++;
        n_checks++;
        if (e_data !== m_slot[DATA_W-1:0]) $display("FAIL latency_data: got %h", e_data);
        else n_pass++;
        tick();
        n_checks++;
        if (e_valid !== 1'b0) $display("FAIL latency_drain: valid=%b want 0", e_valid);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int exp_ch;
        do_reset();
        e_ready  = 1'b1;
        tx_valid = 2'b11;
        exp_ch   = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            randomize_payload();
            tick();
            if (cyc >= 1) begin
                n_checks++;
                if (e_valid !== 1'b1 || e_ch !== CH_W'(exp_ch))
                    $display("FAIL fair_ch: cyc=%0d valid=%b ch=%0d want 1 %0d",
                             cyc, e_valid, e_ch, exp_ch);
                else n_pass++;
                n_checks++;
                if (e_hdr !== m_slot[ENT_W-1:DATA_W] || e_data !== m_slot[DATA_W-1:0])
                    $display("FAIL fair_data: cyc=%0d hdr=%h want %h",
                             cyc, e_hdr, m_slot[ENT_W-1:DATA_W]);
                else n_pass++;
                exp_ch = (exp_ch + 1) % NUM_CH;
            end
        end
        tx_valid = '0;
        for (int cyc = 0; cyc < 4; cyc++) tick();
    endtask

    task automatic test_afull_ovf();
        do_reset();
        e_ready = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            randomize_payload();
            tx_valid = 2'b10;
            tick();
            n_checks++;
            if (afull[1] !== (mq[1].size() >= DEPTH - SLACK))
                $display("FAIL afull: push=%0d afull=%b count=%0d", p, afull[1], mq[1].size());
            else n_pass++;
            // first push drains into the empty slot, so count=8 after push 9
            if (p == 9) begin
                n_checks++;
                if (fill[CNT_W +: CNT_W] !== CNT_W'(8) || ovf !== 2'b00)
                    $display("FAIL full_no_ovf: count=%0d ovf=%b want 8 00",
                             fill[CNT_W +: CNT_W], ovf);
                else n_pass++;
            end
        end
        tx_valid = '0;
        n_checks++;
        if (fill[CNT_W +: CNT_W] !== CNT_W'(8) || ovf !== 2'b10)
            $display("FAIL overflow: count=%0d ovf=%b want 8 10", fill[CNT_W +: CNT_W], ovf);
        else n_pass++;
    endtask

    // Runs from the full state left by test_afull_ovf.
    task automatic test_stall();
        logic [HDR_W-1:0]  h0;
        h0 = m_slot[ENT_W-1:DATA_W];
        e_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            n_checks++;
            if (e_valid !== 1'b1 || e_hdr !== h0 || e_data !== m_slot[DATA_W-1:0] ||
                e_ch !== CH_W'(1))
                $display("FAIL stall_hold: cyc=%0d valid=%b hdr=%h want %h",
                         cyc, e_valid, e_hdr, h0);
            else n_pass++;
        end
        e_ready = 1'b1;
        tick();
        e_ready = 1'b0;
        n_checks++;
        if (e_valid !== 1'b1 || e_hdr !== m_slot[ENT_W-1:DATA_W] || e_hdr === h0)
            $display("FAIL stall_release: hdr=%h want %h", e_hdr, m_slot[ENT_W-1:DATA_W]);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        e_ready = 1'b0;
        for (int p = 0; p < 9; p++) begin
            randomize_payload();
            tx_valid = 2'b10;
            tick();
        end
        e_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            randomize_payload();
            tick();
            n_checks++;
            if (fill[CNT_W +: CNT_W] !== CNT_W'(8) || ovf !== 2'b00)
                $display("FAIL pushpop_full: cyc=%0d count=%0d ovf=%b want 8 00",
                         cyc, fill[CNT_W +: CNT_W], ovf);
            else n_pass++;
            n_checks++;
            if (e_valid !== 1'b1 || e_hdr !== m_slot[ENT_W-1:DATA_W] ||
                e_data !== m_slot[DATA_W-1:0])
                $display("FAIL pushpop_data: cyc=%0d hdr=%h want %h",
                         cyc, e_hdr, m_slot[ENT_W-1:DATA_W]);
            else n_pass++;
        end
        tx_valid = '0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            tick();
            n_checks++;
            if (e_valid !== 1'(m_valid) || (m_valid && e_hdr !== m_slot[ENT_W-1:DATA_W]) ||
                fill[CNT_W +: CNT_W] !== CNT_W'(mq[1].size()))
                $display("FAIL drain: cyc=%0d valid=%b hdr=%h want %b %h",
                         cyc, e_valid, e_hdr, m_valid, m_slot[ENT_W-1:DATA_W]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        e_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            randomize_payload();
            tx_valid = 2'b11;
            tick();
        end
        tx_valid = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_valid = '0;
        n_checks++;
        if (e_valid !== 1'b0 || fill !== '0 || afull !== '0 || ovf !== '0)
            $display("FAIL mid_reset: valid=%b fill=%h afull=%b ovf=%b want all 0",
                     e_valid, fill, afull, ovf);
        else n_pass++;
        e_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            n_checks++;
            if (e_valid !== 1'b0) $display("FAIL mid_reset_replay: cyc=%0d valid=%b", cyc, e_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            randomize_payload();
            tx_valid = NUM_CH'($urandom);
            e_ready  = ($urandom_range(0, 9) < 4);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
            rst = 1'b0;
            n_checks++;
            if (e_valid !== 1'(m_valid)) $display("FAIL rnd_valid: cyc=%0d got %b want %b",
                                                 cyc, e_valid, m_valid);
            else n_pass++;
            n_checks++;
            if (e_hdr !== m_slot[ENT_W-1:DATA_W] || e_data !== m_slot[DATA_W-1:0] ||
                e_ch !== CH_W'(m_ch))
                $display("FAIL rnd_slot: cyc=%0d hdr=%h ch=%0d want %h %0d",
                         cyc, e_hdr, e_ch, m_slot[ENT_W-1:DATA_W], m_ch);
            else n_pass++;
            for (int i = 0; i < NUM_CH; i++) begin
                n_checks++;
                if (fill[i*CNT_W +: CNT_W] !== CNT_W'(mq[i].size()) ||
                    afull[i] !== (mq[i].size() >= DEPTH - SLACK) || ovf[i] !== m_ovf[i])
                    $display("FAIL rnd_ch%0d: cyc=%0d count=%0d afull=%b ovf=%b want %0d %b",
                             i, cyc, fill[i*CNT_W +: CNT_W], afull[i], ovf[i],
                             mq[i].size(), m_ovf[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = '0;
        e_ready  = 1'b0;
        tx_hdr   = '0;
        tx_data  = '0;
        m_valid  = 0;
        m_slot   = '0;
        m_ch     = 0;
        m_last   = NUM_CH - 1;
        m_ovf    = '0;
        test_reset();
        test_latency();
        test_fairness();
        test_afull_ovf();
        test_stall();
        test_full_pushpop();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
